// File: rtl/vc_rotation_mux_barrel_pipe.sv
// Pipelined barrel rotator for vector-compute lanes: normalise stage followed by
// ADDR_WIDTH registered log-stages, each with valid/ready and local backpressure.
module vc_rotation_mux_barrel_pipe #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_ELEMENTS = 16,
    parameter int ADDR_WIDTH   = $clog2(NUM_ELEMENTS),
    parameter int LATENCY      = ADDR_WIDTH + 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [DATA_WIDTH*NUM_ELEMENTS-1:0] data_in,
    input  logic [ADDR_WIDTH-1:0]              addr_in,
    input  logic                               dir_in,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [DATA_WIDTH*NUM_ELEMENTS-1:0] data_out
);

    localparam int VEC_W  = DATA_WIDTH * NUM_ELEMENTS;
    localparam int STAGES = LATENCY;

    logic [VEC_W-1:0]      data_p  [STAGES];
    logic [ADDR_WIDTH-1:0] amt_p   [STAGES];
    logic [STAGES-1:0]     vld_p;
    logic [STAGES-1:0]     rdy_p;
    logic [STAGES-1:0]     vld_in;
    logic [VEC_W-1:0]      data_nx [STAGES];
    logic [ADDR_WIDTH-1:0] amt_nx  [STAGES];

    // Lane i takes lane (i+shift)%N.
    function automatic logic [VEC_W-1:0] rotate_back(input logic [VEC_W-1:0] vec,
                                                     input int shift);
        logic [VEC_W-1:0] res;
        int src;
        res = '0;
        for (int i = 0; i < NUM_ELEMENTS; i++) begin
            src = (i + shift) % NUM_ELEMENTS;
            res[i*DATA_WIDTH +: DATA_WIDTH] = vec[src*DATA_WIDTH +: DATA_WIDTH];
        end
        return res;
    endfunction

    // Reduce modulo N, then express a forward rotation as the equivalent back rotation.
    function automatic logic [ADDR_WIDTH-1:0] norm_amt(input logic [ADDR_WIDTH-1:0] addr,
                                                       input logic dir);
        int a;
        int r;
        a = int'(addr) % NUM_ELEMENTS;
        r = dir ? (NUM_ELEMENTS - a) % NUM_ELEMENTS : a;
        return r[ADDR_WIDTH-1:0];
    endfunction

    assign vld_in = {vld_p[STAGES-2:0], in_valid};

    // Stage 0 takes the normalised input; stage k applies rotation by 2^(k-1) % N.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            data_nx[k] = '0;
            amt_nx[k]  = '0;
        end
        data_nx[0] = data_in;
        amt_nx[0]  = norm_amt(addr_in, dir_in);
        for (int k = 1; k < STAGES; k++) begin
            amt_nx[k]  = amt_p[k-1];
            data_nx[k] = amt_p[k-1][k-1]
                       ? rotate_back(data_p[k-1], (1 << (k-1)) % NUM_ELEMENTS)
                       : data_p[k-1];
        end
    end

    // A stage can load when any stage from it to the output is empty, or the sink accepts.
    always_comb begin
        logic full;
        rdy_p = '0;
        for (int j = 0; j < STAGES; j++) begin
            full = 1'b1;
            for (int m = j; m < STAGES; m++) begin
                full = full & vld_p[m];
            end
            rdy_p[j] = out_ready | ~full;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p <= '0;
            for (int j = 0; j < STAGES; j++) begin
                data_p[j] <= '0;
                amt_p[j]  <= '0;
            end
        end else begin
            for (int j = 0; j < STAGES; j++) begin
                if (rdy_p[j]) begin
                    vld_p[j] <= vld_in[j];
                    if (vld_in[j]) begin
                        data_p[j] <= data_nx[j];
                        amt_p[j]  <= amt_nx[j];
                    end
                end
            end
        end
    end

    assign in_ready  = rdy_p[0];
    assign out_valid = vld_p[STAGES-1];
    assign data_out  = data_p[STAGES-1];

endmodule

// File: tb/tb_vc_rotation_mux_barrel_pipe.sv
// Directed bench for vc_rotation_mux_barrel_pipe: a 16-lane and a 12-lane instance, 8-bit lanes.
module tb_vc_rotation_mux_barrel_pipe;

    localparam logic [127:0] LANES16 = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [95:0]  LANES12 = 96'h0b0a09080706050403020100;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         iv16, ir16, ov16, or16, dir16;
    logic [127:0] din16, dout16;
    logic [3:0]   addr16;
    logic         iv12, ir12, ov12, or12, dir12;
    logic [95:0]  din12, dout12;
    logic [3:0]   addr12;

    int tests_run    = 0;
    int tests_failed = 0;

    vc_rotation_mux_barrel_pipe #(.DATA_WIDTH(8), .NUM_ELEMENTS(16)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .data_in(din16),
        .addr_in(addr16), .dir_in(dir16), .out_valid(ov16), .out_ready(or16),
        .data_out(dout16)
    );

    vc_rotation_mux_barrel_pipe #(.DATA_WIDTH(8), .NUM_ELEMENTS(12)) u_dut12 (
        .clk(clk), .rst(rst), .in_valid(iv12), .in_ready(ir12), .data_in(din12),
        .addr_in(addr12), .dir_in(dir12), .out_valid(ov12), .out_ready(or12),
        .data_out(dout12)
    );

    // Lane i of LANES16 rotated back by r holds value (i+r)%16.
    function automatic logic [127:0] exp_back16(input int r);
        logic [127:0] v;
        for (int i = 0; i < 16; i++) v[i*8 +: 8] = 8'((i + r) % 16);
        return v;
    endfunction

    task automatic run16(input logic [3:0] a, input logic d,
                         output logic [127:0] dout, output int lat, output int vcyc);
        @(negedge clk);
        iv16 = 1'b1; din16 = LANES16; addr16 = a; dir16 = d; or16 = 1'b1;
        @(negedge clk);
        iv16 = 1'b0; din16 = '0; addr16 = '0; dir16 = 1'b0;
        lat = 1;
        while (!ov16 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        dout = dout16;
        vcyc = 0;
        while (ov16 && vcyc < 20) begin
            vcyc++;
            @(negedge clk);
        end
    endtask

    task automatic run12(input logic [3:0] a, input logic d,
                         output logic [95:0] dout, output int lat, output int vcyc);
        @(negedge clk);
        iv12 = 1'b1; din12 = LANES12; addr12 = a; dir12 = d; or12 = 1'b1;
        @(negedge clk);
        iv12 = 1'b0; din12 = '0; addr12 = '0; dir12 = 1'b0;
        lat = 1;
        while (!ov12 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        dout = dout12;
        vcyc = 0;
        while (ov12 && vcyc < 20) begin
            vcyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        iv16 = 0; or16 = 1; dir16 = 0; din16 = '0; addr16 = '0;
        iv12 = 0; or12 = 1; dir12 = 0; din12 = '0; addr12 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        tests_run++;
        if (ov16 !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid16 got %b want 0", ov16); end
        tests_run++;
        if (dout16 !== 128'h0) begin tests_failed++; $display("FAIL reset_data_out16 got %h want 0", dout16); end
        tests_run++;
        if (ir16 !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready16 got %b want 1", ir16); end
        tests_run++;
        if (ov12 !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid12 got %b want 0", ov12); end
        tests_run++;
        if (ir12 !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready12 got %b want 1", ir12); end
    endtask

    task automatic test_back_rotation;
        logic [127:0] d;
        int lat, vc;
        run16(4'd3, 1'b0, d, lat, vc);
        tests_run++;
        if (d !== 128'h0201000f0e0d0c0b0a09080706050403) begin
            tests_failed++; $display("FAIL back3_data got %h want 0201000f0e0d0c0b0a09080706050403", d);
        end
        tests_run++;
        if (lat !== 5) begin tests_failed++; $display("FAIL back3_latency got %0d want 5", lat); end
        tests_run++;
        if (vc !== 1) begin tests_failed++; $display("FAIL back3_valid_cycles got %0d want 1", vc); end
        run16(4'd0, 1'b0, d, lat, vc);
        tests_run++;
        if (d !== LANES16) begin tests_failed++; $display("FAIL back0_identity got %h want %h", d, LANES16); end
    endtask

    task automatic test_forward_rotation;
        logic [127:0] d;
        int lat, vc;
        run16(4'd3, 1'b1, d, lat, vc);
        tests_run++;
        if (d !== 128'h0c0b0a090807060504030201000f0e0d) begin
            tests_failed++; $display("FAIL fwd3_data got %h want 0c0b0a090807060504030201000f0e0d", d);
        end
        tests_run++;
        if (vc !== 1) begin tests_failed++; $display("FAIL fwd3_valid_cycles got %0d want 1", vc); end
        run16(4'd0, 1'b1, d, lat, vc);
        tests_run++;
        if (d !== LANES16) begin tests_failed++; $display("FAIL fwd0_identity got %h want %h", d, LANES16); end
    endtask

    task automatic test_npot;
        logic [95:0] d;
        int lat, vc;
        run12(4'd13, 1'b0, d, lat, vc);
        tests_run++;
        if (d !== 96'h000b0a090807060504030201) begin
            tests_failed++; $display("FAIL npot_back13 got %h want 000b0a090807060504030201", d);
        end
        tests_run++;
        if (lat !== 5) begin tests_failed++; $display("FAIL npot_latency got %0d want 5", lat); end
        run12(4'd5, 1'b1, d, lat, vc);
        tests_run++;
        if (d !== 96'h060504030201000b0a090807) begin
            tests_failed++; $display("FAIL npot_fwd5 got %h want 060504030201000b0a090807", d);
        end
        run12(4'd0, 1'b1, d, lat, vc);
        tests_run++;
        if (d !== LANES12) begin tests_failed++; $display("FAIL npot_fwd0_identity got %h want %h", d, LANES12); end
    endtask

    task automatic test_back_to_back;
        int sent = 0;
        int got = 0;
        int cyc = 0;
        int fills = 0;
        logic prev_stall = 1'b0;
        logic [127:0] prev_data = '0;
        while (got < 16 && cyc < 200) begin
            @(negedge clk);
            or16 = (cyc % 4 == 0) || (cyc % 4 == 3);
            iv16 = (sent < 16);
            addr16 = sent[3:0];
            din16 = LANES16;
            dir16 = 1'b0;
            #1;
            if (prev_stall) begin
                tests_run++;
                if (ov16 !== 1'b1 || dout16 !== prev_data) begin
                    tests_failed++;
                    $display("FAIL b2b_stall_stable got v=%b %h want v=1 %h", ov16, dout16, prev_data);
                end
            end
            if (ir16 === 1'b0) begin
                fills++;
                tests_run++;
                if (sent - got !== 5) begin
                    tests_failed++; $display("FAIL b2b_full_occupancy got %0d want 5", sent - got);
                end
            end
            if (ov16 && or16) begin
                tests_run++;
                if (dout16 !== exp_back16(got)) begin
                    tests_failed++; $display("FAIL b2b_out%0d got %h want %h", got, dout16, exp_back16(got));
                end
                got++;
            end
            prev_stall = ov16 && !or16;
            prev_data = dout16;
            if (iv16 && ir16) sent++;
            cyc++;
        end
        tests_run++;
        if (got !== 16) begin tests_failed++; $display("FAIL b2b_count got %0d want 16", got); end
        tests_run++;
        if (fills == 0) begin tests_failed++; $display("FAIL b2b_in_ready_drop got %0d drops want >0", fills); end
        @(negedge clk);
        iv16 = 1'b0; or16 = 1'b1;
    endtask

    task automatic test_drain;
        int acc = 0;
        int n = 0;
        while (acc < 20) begin
            @(negedge clk);
            or16 = 1'b0; iv16 = 1'b1; addr16 = acc[3:0]; din16 = LANES16; dir16 = 1'b0;
            #1;
            if (!ir16) break;
            acc++;
        end
        tests_run++;
        if (acc !== 5) begin tests_failed++; $display("FAIL drain_stored got %0d want 5", acc); end
        iv16 = 1'b0; or16 = 1'b1;
        #1;
        tests_run++;
        if (ir16 !== 1'b1) begin tests_failed++; $display("FAIL drain_in_ready got %b want 1", ir16); end
        tests_run++;
        if (ov16 !== 1'b1) begin tests_failed++; $display("FAIL drain_first_valid got %b want 1", ov16); end
        while (ov16 && n < 10) begin
            tests_run++;
            if (dout16 !== exp_back16(n)) begin
                tests_failed++; $display("FAIL drain_out%0d got %h want %h", n, dout16, exp_back16(n));
            end
            n++;
            @(negedge clk);
            #1;
        end
        tests_run++;
        if (n !== 5) begin tests_failed++; $display("FAIL drain_valid_cycles got %0d want 5", n); end
    endtask

    task automatic test_mid_reset;
        int seen = 0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            iv16 = 1'b1; or16 = 1'b0; addr16 = 4'(k); din16 = LANES16; dir16 = 1'b0;
        end
        @(negedge clk);
        iv16 = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (ov16 !== 1'b1 || dout16 !== exp_back16(1)) begin
            tests_failed++; $display("FAIL midrst_pre got v=%b %h want v=1 %h", ov16, dout16, exp_back16(1));
        end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (ov16 !== 1'b0) begin tests_failed++; $display("FAIL midrst_out_valid got %b want 0", ov16); end
        tests_run++;
        if (dout16 !== 128'h0) begin tests_failed++; $display("FAIL midrst_data_out got %h want 0", dout16); end
        @(negedge clk);
        rst = 1'b0; or16 = 1'b1;
        #1;
        tests_run++;
        if (ir16 !== 1'b1) begin tests_failed++; $display("FAIL midrst_in_ready got %b want 1", ir16); end
        repeat (8) begin
            @(negedge clk);
            if (ov16 !== 1'b0) seen++;
        end
        tests_run++;
        if (seen !== 0) begin tests_failed++; $display("FAIL midrst_stale_outputs got %0d want 0", seen); end
    endtask

    initial begin
        test_reset();
        test_back_rotation();
        test_forward_rotation();
        test_npot();
        test_back_to_back();
        test_drain();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout got running want finished");
        $fatal(1);
    end

endmodule

// File: doc/vc_rotation_mux_barrel_pipe.md
Name: vc_rotation_mux_barrel_pipe

Overview:
- Parametrised, fully pipelined barrel rotator for vector-compute lanes.
- Rotates a packed vector of NUM_ELEMENTS lanes by a per-transaction amount in either direction.
- Decomposes the rotation into ADDR_WIDTH log-stages, each registered, with a valid/ready handshake and per-stage backpressure.
- Sits between the lane register file and the VC execution lanes; replaces the single-stage back/forward rotation muxes.

Parameters:
- DATA_WIDTH, 32, bits per lane element.
- NUM_ELEMENTS, 16, lane count; any value >= 2, power of two not required.
- ADDR_WIDTH, $clog2(NUM_ELEMENTS), rotation-amount width; derived, not set manually.
- LATENCY, ADDR_WIDTH+1, pipeline depth in cycles; derived, not set manually.

Ports:
- clk, input, 1, sole clock; all state updates on posedge.
- rst, input, 1, asynchronous, active-high reset.
- in_valid, input, 1, input transaction valid.
- in_ready, output, 1, block can accept an input this cycle.
- data_in, input, DATA_WIDTH*NUM_ELEMENTS, packed lanes; lane i occupies bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH].
- addr_in, input, ADDR_WIDTH, rotation amount.
- dir_in, input, 1, 0 = back (out[i] = in[(i+addr)%N]), 1 = forward (out[i] = in[(i-addr)%N]).
- out_valid, output, 1, output transaction valid.
- out_ready, input, 1, downstream accepts the output.
- data_out, output, DATA_WIDTH*NUM_ELEMENTS, rotated packed lanes.

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is asynchronous and active-high.
- Reset values: all stage valid bits = 0, all stage data and amount registers = 0, so out_valid = 0 and data_out = 0. in_ready = 1 immediately after reset deasserts.
- Stage 0 (normalise):
  - On an accepted input (in_valid & in_ready), capture data_in.
  - Reduce the amount: a = addr_in % NUM_ELEMENTS. This only matters when N is not a power of two and addr_in >= N.
  - Convert to a back-rotation amount r:
    - r = a when dir_in = 0.
    - r = (N - a) % N when dir_in = 1.
    - a = 0 gives r = 0 in both directions.
- Stages k = 1..ADDR_WIDTH:
  - If bit k-1 of r is set, rotate back by s = 2^(k-1) % N: lane i takes lane (i+s)%N of the previous stage. Otherwise pass through.
  - Carry r forward with the data.
  - r < N guarantees the composed rotation equals r mod N for any N.
- Output: data_out and out_valid are driven directly from the final stage's registers, with no combinational path from data_in.
- Handshake:
  - Stage j advances when it is empty, or when stage j+1 accepts its contents. The ready into the final stage is out_ready.
  - in_ready = !valid[0] | ready[1]. This is a combinational backward ready chain; there is no combinational path from in_valid to in_ready.
  - Input transfer: in_valid & in_ready at a posedge. Output transfer: out_valid & out_ready at a posedge.
  - data_in, addr_in and dir_in are ignored when in_valid = 0 or in_ready = 0.
- Throughput and latency:
  - One transaction per cycle while out_ready is held high.
  - An input accepted at edge t appears with out_valid = 1 after edge t+LATENCY-1, and is visible during cycle t+LATENCY.
- Stall:
  - While out_ready = 0, the final stage holds; data_out and out_valid must stay stable.
  - Upstream stages keep filling bubbles until every stage is valid; only then does in_ready drop.
  - When out_ready returns, the pipeline drains in order, with no loss and no duplication.
- Ordering: strictly FIFO; the pipeline holds at most LATENCY transactions.
- Simultaneous events: a full stage whose successor accepts on the same edge may take a new entry on that edge (pass-through occupancy).
- Reset mid-operation: all in-flight transactions are discarded, and outputs return to their reset values asynchronously.

Test Plan:
- Back rotation: N=16, DATA_WIDTH=8, lane i = i, dir=0, addr=3, out_ready=1 -> after 5 cycles data_out lanes = 3,4,...,15,0,1,2 with out_valid = 1 for exactly one cycle.
- Forward rotation: same data, dir=1, addr=3 -> lanes = 13,14,15,0,...,12; addr=0 in either direction -> identity.
- Non-power-of-two: N=12, DATA_WIDTH=8, lane i = i:
  - addr=13, dir=0 -> reduced to 1; lanes = 1..11,0.
  - addr=5, dir=1 -> lanes = 7..11,0..6.
- Back-to-back with backpressure: N=16, DATA_WIDTH=8, lane i = i. Stream addr 0..15 with in_valid held high and out_ready toggled 1,0,0,1 ->
  - outputs appear in order, each correct;
  - in_ready falls only after 5 entries are held;
  - data_out is stable while out_valid = 1 and out_ready = 0.
- Full pipeline drain: hold out_ready = 0 until in_ready = 0 -> exactly 5 transactions stored. Then raise out_ready -> 5 consecutive out_valid cycles, with in_ready high again on the first of them.
- Mid-flight reset: assert rst asynchronously with 3 transactions in flight -> out_valid = 0 and data_out = 0 immediately. After release, no stale output appears and in_ready = 1.
